lsu_store_buffered: RTL and testbench
=====================================

// Module: lsu_store_buffered
// PURPOSE
//  Next-generation load/store execution unit between the LSB and the memory controller.
//  Adds XLEN/depth parametrisation, an in-order store buffer and a single load slot.
//  Also adds misalignment detection and load/store address-conflict ordering.
//  Loads bypass buffered stores unless their word addresses overlap.
//  Stores arrive already committed and survive ROB rollback; loads are cancelled by rollback.
// PARAMETERS
//  XLEN      32  data width of results and store data
//  AW        32  address width
//  SB_DEPTH  4   store-buffer entries (power of 2, >=2)
// PORTS
//  clk_in            in   1      clock, rising edge
//  rst_n_in          in   1      reset, asynchronous, active-low
//  rdy_in            in   1      global stall: when 0, hold all state and outputs
//  req_valid_in      in   1      request from LSB
//  req_ready_out     out  1      request accepted when valid&&ready at a clock edge
//  req_op_in         in   4      [3]=store, [2:0]=funct3 (LB0 LH1 LW2 LBU4 LHU5 / SB0 SH1 SW2)
//  req_addr_in       in   AW     effective address
//  req_data_in       in   XLEN   store data (low bytes used)
//  res_valid_out     out  1      one-cycle pulse: load result or misalign report
//  res_data_out      out  XLEN   extended load data
//  res_misalign_out  out  1      qualifies res_valid_out: access was misaligned
//  mem_en_out        out  1      one-cycle request pulse to memory controller
//  mem_rw_out        out  1      0=read, 1=write
//  mem_addr_out      out  AW     access address
//  mem_data_out      out  XLEN   write data
//  mem_size_out      out  3      1, 2 or 4 bytes
//  mem_ok_in         in   1      memory completion pulse (read data valid same cycle)
//  mem_data_in       in   XLEN   read data, byte 0 in [7:0]
//  rollback_in       in   1      ROB misprediction flush
//  sb_empty_out      out  1      store buffer empty and no store in flight
// BEHAVIOUR
//  Reset: every output is 0 except sb_empty_out=1; FSM=IDLE; SB and load slot are empty.
//  Readiness: req_ready_out = op[3] ? !sb_full : !load_slot_valid.
//   It depends only on op and state, never on req_valid_in.
//  Misaligned request: a half with addr[0]!=0 or a word with addr[1:0]!=0.
//   It is accepted but never queued.
//   Next cycle: res_valid_out=1, res_misalign_out=1, res_data_out=0.
//  Accepted aligned store: pushed into the SB tail (addr, data, size).
//  Accepted aligned load: written to the load slot.
//  FSM states: IDLE, LOAD_WAIT, STORE_WAIT, LOAD_DROP.
//  IDLE arbitration, evaluated each cycle; the first matching rule wins:
//   1) Load slot valid, and no SB entry has addr[AW-1:2] equal to the load's
//      -> issue the read; go to LOAD_WAIT.
//   2) SB not empty -> issue the SB head as a write; go to STORE_WAIT.
//   An issue drives mem_en_out=1 for exactly one cycle; mem_* holds until completion.
//  LOAD_WAIT on mem_ok_in: extend the data per funct3
//   (LB/LH sign-extend; LBU/LHU zero-extend; LW passes through).
//   Then res_valid_out=1 for one cycle, clear the load slot, go to IDLE.
//  STORE_WAIT on mem_ok_in: pop the SB head; go to IDLE.
//  rollback_in=1:
//   - clears an unissued load slot;
//   - LOAD_WAIT -> LOAD_DROP, which waits for mem_ok_in, discards the data, goes to IDLE;
//   - suppresses a same-cycle misalign report and a same-cycle load acceptance;
//   - leaves the SB and STORE_WAIT untouched.
//  Simultaneous accept and pop: allowed when the SB is full; occupancy is unchanged.
//  A load accepted in the same cycle as a store uses the SB contents from after the push.
//  SB pointers wrap modulo SB_DEPTH; full/empty use an extra pointer bit.
//  Latency: accept at edge E0 -> mem_en_out at E1 at the earliest.
//   Result pulse at the edge after mem_ok_in.
//  Reset mid-operation: all state is discarded at once, including SB contents.
//   A later mem_ok_in is ignored.
// TESTING
//  LB/LBU/LH/LHU with mem_data_in=0x00008080 -> 0xFFFFFF80, 0x80, 0xFFFF8080, 0x8080;
//   mem_size_out 1,1,2,2.
//  SW 0x100 then LW 0x104 -> read issues before the write.
//   SW 0x100 then LW 0x100 -> write completes first, then the read.
//  Push 4 stores with memory stalled -> req_ready_out=0 for stores, 1 for loads.
//   On a pop, a new push is accepted the same cycle.
//  LW in LOAD_WAIT, rollback_in pulse, mem_ok 3 cycles later -> no res_valid_out.
//   The next LW completes normally.
//  LW 0x102 / SH 0x101 -> res_valid_out=1, res_misalign_out=1, no mem_en_out.
//  rst_n_in low during STORE_WAIT -> outputs 0 and sb_empty_out=1 immediately.
//   The stale mem_ok_in is ignored.

Source files
------------

// File: rtl/lsu_store_buffered.sv
// Load/store unit with an in-order store buffer and a single load slot. Loads bypass
// buffered stores unless their word addresses overlap; rollback cancels loads only.
module lsu_store_buffered #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 32,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            rdy_in,
  input  logic            req_valid_in,
  output logic            req_ready_out,
  input  logic [3:0]      req_op_in,
  input  logic [AW-1:0]   req_addr_in,
  input  logic [XLEN-1:0] req_data_in,
  output logic            res_valid_out,
  output logic [XLEN-1:0] res_data_out,
  output logic            res_misalign_out,
  output logic            mem_en_out,
  output logic            mem_rw_out,
  output logic [AW-1:0]   mem_addr_out,
  output logic [XLEN-1:0] mem_data_out,
  output logic [2:0]      mem_size_out,
  input  logic            mem_ok_in,
  input  logic [XLEN-1:0] mem_data_in,
  input  logic            rollback_in,
  output logic            sb_empty_out
);

  localparam int unsigned PW = $clog2(SB_DEPTH);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] LOAD_WAIT  = 2'd1;
  localparam logic [1:0] STORE_WAIT = 2'd2;
  localparam logic [1:0] LOAD_DROP  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            run_q;
  logic [PW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   sb_addr_q [SB_DEPTH];
  logic [XLEN-1:0] sb_data_q [SB_DEPTH];
  logic [1:0]      sb_size_q [SB_DEPTH];
  logic            ld_valid_q, ld_valid_d;
  logic [AW-1:0]   ld_addr_q, ld_addr_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic            mem_en_q, mem_en_d, mem_rw_q, mem_rw_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_data_q, mem_data_d;
  logic [2:0]      mem_size_q, mem_size_d;
  logic            res_valid_q, res_valid_d, res_misalign_q, res_misalign_d;
  logic [XLEN-1:0] res_data_q, res_data_d;
  logic            mis_pend_q, mis_pend_d;

  logic [PW:0]     sb_count;
  logic [PW-1:0]   rd_idx, wr_idx, off;
  logic            sb_full, sb_empty, pop, is_store, misalign, accept;
  logic            push, ld_acc, mis_now, conflict, load_done;

  function automatic logic [2:0] size_of(input logic [1:0] f);
    case (f)
      2'd0:    size_of = 3'd1;
      2'd1:    size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [2:0] f, input logic [XLEN-1:0] d);
    case (f)
      3'd0:    extend = {{(XLEN-8){d[7]}}, d[7:0]};
      3'd1:    extend = {{(XLEN-16){d[15]}}, d[15:0]};
      3'd4:    extend = {{(XLEN-8){1'b0}}, d[7:0]};
      3'd5:    extend = {{(XLEN-16){1'b0}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign sb_count = wr_ptr_q - rd_ptr_q;
  assign rd_idx   = rd_ptr_q[PW-1:0];
  assign wr_idx   = wr_ptr_q[PW-1:0];
  assign sb_full  = (sb_count == (PW+1)'(SB_DEPTH));
  assign sb_empty = (sb_count == '0);
  assign pop      = (state_q == STORE_WAIT) && mem_ok_in;
  assign is_store = req_op_in[3];
  assign misalign = ((req_op_in[1:0] == 2'd1) && req_addr_in[0]) ||
                    ((req_op_in[1:0] == 2'd2) && (req_addr_in[1:0] != 2'b00));

  // A head pop this cycle frees a slot, so a full buffer can still take a store.
  assign req_ready_out = rdy_in && run_q && (is_store ? (!sb_full || pop) : !ld_valid_q);
  assign accept  = req_valid_in && req_ready_out;
  assign push    = accept && is_store && !misalign;
  assign ld_acc  = accept && !is_store && !misalign && !rollback_in;
  assign mis_now = accept && misalign && !rollback_in;

  always_comb begin
    conflict = 1'b0;
    off      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      off = PW'(i) - rd_idx;
      if (({1'b0, off} < sb_count) && (sb_addr_q[i][AW-1:2] == ld_addr_q[AW-1:2])) begin
        conflict = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    ld_valid_d     = ld_valid_q;
    ld_addr_d      = ld_addr_q;
    ld_f3_d        = ld_f3_q;
    mem_en_d       = 1'b0;
    mem_rw_d       = mem_rw_q;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    mem_size_d     = mem_size_q;
    res_valid_d    = 1'b0;
    res_misalign_d = 1'b0;
    res_data_d     = '0;
    mis_pend_d     = 1'b0;
    load_done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (ld_valid_q && !conflict && !rollback_in) begin
          mem_en_d   = 1'b1;
          mem_rw_d   = 1'b0;
          mem_addr_d = ld_addr_q;
          mem_data_d = '0;
          mem_size_d = size_of(ld_f3_q[1:0]);
          state_d    = LOAD_WAIT;
        end else if (!sb_empty) begin
          mem_en_d   = 1'b1;
          mem_rw_d   = 1'b1;
          mem_addr_d = sb_addr_q[rd_idx];
          mem_data_d = sb_data_q[rd_idx];
          mem_size_d = size_of(sb_size_q[rd_idx]);
          state_d    = STORE_WAIT;
        end
      end
      LOAD_WAIT: begin
        if (rollback_in) begin
          // Data arriving in the flush cycle is dropped here rather than awaited.
          state_d = mem_ok_in ? IDLE : LOAD_DROP;
        end else if (mem_ok_in) begin
          load_done  = 1'b1;
          ld_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      STORE_WAIT: begin
        if (mem_ok_in) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          state_d  = IDLE;
        end
      end
      LOAD_DROP: begin
        if (mem_ok_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rollback_in) ld_valid_d = 1'b0;
    if (ld_acc) begin
      ld_valid_d = 1'b1;
      ld_addr_d  = req_addr_in;
      ld_f3_d    = req_op_in[2:0];
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    // One result per cycle; a misalign report colliding with a load result slips a cycle.
    if (load_done) begin
      res_valid_d = 1'b1;
      res_data_d  = extend(ld_f3_q, mem_data_in);
      mis_pend_d  = mis_now || mis_pend_q;
    end else if (mis_pend_q || mis_now) begin
      res_valid_d    = 1'b1;
      res_misalign_d = 1'b1;
      mis_pend_d     = mis_pend_q && mis_now;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= IDLE;
      run_q          <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      ld_valid_q     <= 1'b0;
      ld_addr_q      <= '0;
      ld_f3_q        <= '0;
      mem_en_q       <= 1'b0;
      mem_rw_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      mem_size_q     <= '0;
      res_valid_q    <= 1'b0;
      res_misalign_q <= 1'b0;
      res_data_q     <= '0;
      mis_pend_q     <= 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= '0;
        sb_data_q[i] <= '0;
        sb_size_q[i] <= '0;
      end
    end else begin
      run_q <= 1'b1;
      if (rdy_in) begin
        state_q        <= state_d;
        wr_ptr_q       <= wr_ptr_d;
        rd_ptr_q       <= rd_ptr_d;
        ld_valid_q     <= ld_valid_d;
        ld_addr_q      <= ld_addr_d;
        ld_f3_q        <= ld_f3_d;
        mem_en_q       <= mem_en_d;
        mem_rw_q       <= mem_rw_d;
        mem_addr_q     <= mem_addr_d;
        mem_data_q     <= mem_data_d;
        mem_size_q     <= mem_size_d;
        res_valid_q    <= res_valid_d;
        res_misalign_q <= res_misalign_d;
        res_data_q     <= res_data_d;
        mis_pend_q     <= mis_pend_d;
        if (push) begin
          sb_addr_q[wr_idx] <= req_addr_in;
          sb_data_q[wr_idx] <= req_data_in;
          sb_size_q[wr_idx] <= req_op_in[1:0];
        end
      end
    end
  end

  assign res_valid_out    = res_valid_q;
  assign res_data_out     = res_data_q;
  assign res_misalign_out = res_misalign_q;
  assign mem_en_out       = mem_en_q;
  assign mem_rw_out       = mem_rw_q;
  assign mem_addr_out     = mem_addr_q;
  assign mem_data_out     = mem_data_q;
  assign mem_size_out     = mem_size_q;
  assign sb_empty_out     = sb_empty && (state_q != STORE_WAIT);

endmodule

// File: tb/tb_lsu_store_buffered.sv
// Directed bench for lsu_store_buffered: load extension, store/load ordering,
// buffer-full back-pressure, rollback, misalignment and mid-operation reset.
module tb_lsu_store_buffered;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        res_valid, res_misalign;
  logic [31:0] res_data;
  logic        mem_en, mem_rw;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_size;
  logic        mem_ok = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rollback = 1'b0;
  logic        sb_empty;

  int n_checks = 0;
  int n_errors = 0;

  lsu_store_buffered #(.XLEN(32), .AW(32), .SB_DEPTH(4)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .rdy_in           (rdy),
    .req_valid_in     (req_valid),
    .req_ready_out    (req_ready),
    .req_op_in        (req_op),
    .req_addr_in      (req_addr),
    .req_data_in      (req_data),
    .res_valid_out    (res_valid),
    .res_data_out     (res_data),
    .res_misalign_out (res_misalign),
    .mem_en_out       (mem_en),
    .mem_rw_out       (mem_rw),
    .mem_addr_out     (mem_addr),
    .mem_data_out     (mem_wdata),
    .mem_size_out     (mem_size),
    .mem_ok_in        (mem_ok),
    .mem_data_in      (mem_rdata),
    .rollback_in      (rollback),
    .sb_empty_out     (sb_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_mem_en(input string tag);
    for (int i = 0; i < 8 && !mem_en; i++) @(negedge clk);
    check({tag, "_en"}, {31'b0, mem_en}, 32'd1);
  endtask

  task automatic mem_resp(input logic [31:0] data);
    mem_ok    = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_ok    = 1'b0;
    mem_rdata = '0;
  endtask

  logic [3:0]  ld_op   [4] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101};
  logic [31:0] ld_addr [4] = '{32'h40, 32'h41, 32'h42, 32'h46};
  logic [31:0] ld_exp  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8080, 32'h0000_8080};
  logic [2:0]  ld_size [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
  logic        seen;

  initial begin
    // Reset state
    #2;
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load extension and size
    for (int k = 0; k < 4; k++) begin
      send(ld_op[k], ld_addr[k], 32'd0);
      wait_mem_en("ld");
      check("ld_rw", {31'b0, mem_rw}, 32'd0);
      check("ld_addr", mem_addr, ld_addr[k]);
      check("ld_size", {29'b0, mem_size}, {29'b0, ld_size[k]});
      @(negedge clk);
      check("ld_en_pulse", {31'b0, mem_en}, 32'd0);
      mem_resp(32'h0000_8080);
      check("ld_res_valid", {31'b0, res_valid}, 32'd1);
      check("ld_data", res_data, ld_exp[k]);
      @(negedge clk);
      check("ld_res_pulse", {31'b0, res_valid}, 32'd0);
    end
    send(4'b0010, 32'h44, 32'd0);
    wait_mem_en("lw");
    check("lw_size", {29'b0, mem_size}, 32'd4);
    mem_resp(32'h8765_4321);
    check("lw_data", res_data, 32'h8765_4321);

    // Non-overlapping load bypasses a queued store
    send(4'b1010, 32'h200, 32'hCAFE_0001);
    wait_mem_en("st0");
    check("st0_rw", {31'b0, mem_rw}, 32'd1);
    check("st0_data", mem_wdata, 32'hCAFE_0001);
    send(4'b1010, 32'h100, 32'hDEAD_BEEF);
    send(4'b0010, 32'h104, 32'd0);
    check("byp_sb_empty", {31'b0, sb_empty}, 32'd0);
    mem_resp(32'd0);
    wait_mem_en("byp_rd");
    check("byp_rd_rw", {31'b0, mem_rw}, 32'd0);
    check("byp_rd_addr", mem_addr, 32'h104);
    mem_resp(32'h1122_3344);
    check("byp_rd_data", res_data, 32'h1122_3344);
    wait_mem_en("byp_wr");
    check("byp_wr_rw", {31'b0, mem_rw}, 32'd1);
    check("byp_wr_addr", mem_addr, 32'h100);
    mem_resp(32'd0);
    check("byp_sb_empty_end", {31'b0, sb_empty}, 32'd1);

    // Overlapping load waits for the store
    send(4'b1010, 32'h300, 32'h1);
    wait_mem_en("cf0");
    send(4'b1010, 32'h100, 32'hBEEF_0002);
    send(4'b0010, 32'h100, 32'd0);
    mem_resp(32'd0);
    wait_mem_en("cf_wr");
    check("cf_wr_rw", {31'b0, mem_rw}, 32'd1);
    check("cf_wr_addr", mem_addr, 32'h100);
    mem_resp(32'd0);
    wait_mem_en("cf_rd");
    check("cf_rd_rw", {31'b0, mem_rw}, 32'd0);
    mem_resp(32'hBEEF_0002);
    check("cf_rd_data", res_data, 32'hBEEF_0002);

    // Full buffer back-pressure and same-cycle pop/push
    for (int k = 0; k < 4; k++) send(4'b1010, 32'h400 + 32'(4 * k), 32'(k));
    req_op = 4'b1010;
    #1 check("full_st_ready", {31'b0, req_ready}, 32'd0);
    req_op = 4'b0010;
    #1 check("full_ld_ready", {31'b0, req_ready}, 32'd1);
    check("full_head", mem_addr, 32'h400);
    req_op    = 4'b1010;
    req_addr  = 32'h410;
    req_data  = 32'h4;
    req_valid = 1'b1;
    mem_ok    = 1'b1;
    #1 check("poppush_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    mem_ok    = 1'b0;
    #1 check("still_full", {31'b0, req_ready}, 32'd0);
    for (int k = 1; k < 5; k++) begin
      wait_mem_en("drain");
      check("drain_addr", mem_addr, 32'h400 + 32'(4 * k));
      check("drain_data", mem_wdata, 32'(k));
      mem_resp(32'd0);
    end
    check("drain_sb_empty", {31'b0, sb_empty}, 32'd1);

    // Rollback while a load is in flight
    send(4'b0010, 32'h500, 32'd0);
    wait_mem_en("rb");
    rollback = 1'b1;
    @(negedge clk);
    rollback = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_resp(32'hAAAA_5555);
    check("rb_no_res", {31'b0, res_valid}, 32'd0);
    send(4'b0010, 32'h504, 32'd0);
    wait_mem_en("rb_next");
    check("rb_next_addr", mem_addr, 32'h504);
    mem_resp(32'h1234_5678);
    check("rb_next_valid", {31'b0, res_valid}, 32'd1);
    check("rb_next_data", res_data, 32'h1234_5678);

    // Misaligned word load and half store
    send(4'b0010, 32'h102, 32'd0);
    check("mis_lw_valid", {31'b0, res_valid}, 32'd1);
    check("mis_lw_flag", {31'b0, res_misalign}, 32'd1);
    check("mis_lw_data", res_data, 32'd0);
    send(4'b1001, 32'h101, 32'hFFFF);
    check("mis_sh_valid", {31'b0, res_valid}, 32'd1);
    check("mis_sh_flag", {31'b0, res_misalign}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seen |= mem_en;
      @(negedge clk);
    end
    check("mis_no_mem", {31'b0, seen}, 32'd0);
    check("mis_sb_empty", {31'b0, sb_empty}, 32'd1);

    // Reset during STORE_WAIT with a second store queued
    send(4'b1010, 32'h600, 32'h6);
    wait_mem_en("rst_st");
    send(4'b1010, 32'h604, 32'h7);
    check("pre_rst_sb_empty", {31'b0, sb_empty}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rw", {31'b0, mem_rw}, 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    check("mid_rst_sb_empty", {31'b0, sb_empty}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp(32'd0);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      seen |= mem_en | res_valid;
      @(negedge clk);
    end
    check("post_rst_quiet", {31'b0, seen}, 32'd0);
    check("post_rst_sb_empty", {31'b0, sb_empty}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
